alu_arbiter: RTL

Shares the single combinational EX-stage ALU between two requesters with valid/ready handshakes on both the request and response sides. Requester 0 is the main pipeline EX stage; requester 1 is an auxiliary unit such as a branch/address helper or a future multi-cycle sequencer. The block round-robin-arbitrates requests, drives the ALU operand/opcode inputs, and captures each result and Zero flag into a per-requester one-entry response register. Total throughput is one operation per cycle.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_rsp_buf.sv | 47 ++++
 rtl/alu_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, requester ids and response-register state type
// used by the ALU arbiter slice.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;
  localparam logic [3:0] ALU_SRL = 4'b1110;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam int REQ_EX  = 0;
  localparam int REQ_AUX = 1;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/alu_rsp_buf.sv
// One-entry response register for one requester: loads on grant, empties on
// drain; the state output doubles as the debug view of the entry.
module alu_rsp_buf
  import alu_pkg::*;
#(
  parameter int bit_size = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                rsp_ready,
  input  logic [bit_size-1:0] load_result,
  input  logic                load_zero,
  output rsp_state_e          state,
  output logic [bit_size-1:0] rsp_result,
  output logic                rsp_zero
);

  // A load in the same cycle as a drain wins: the entry is overwritten and stays FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RSP_EMPTY;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        RSP_EMPTY: begin
          if (load) begin
            state      <= RSP_FULL;
            rsp_result <= load_result;
            rsp_zero   <= load_zero;
          end
        end
        RSP_FULL: begin
          if (load) begin
            rsp_result <= load_result;
            rsp_zero   <= load_zero;
          end else if (rsp_ready) begin
            state <= RSP_EMPTY;
          end
        end
        default: state <= RSP_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the EX stage (req 0) and an auxiliary unit (req 1).
// Define ALU_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority to requester 0.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int bit_size = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_0,
  input  logic                req_valid_1,
  output logic                req_ready_0,
  output logic                req_ready_1,
  input  logic [3:0]          req_aluop_0,
  input  logic [3:0]          req_aluop_1,
  input  logic [bit_size-1:0] req_src1_0,
  input  logic [bit_size-1:0] req_src1_1,
  input  logic [bit_size-1:0] req_src2_0,
  input  logic [bit_size-1:0] req_src2_1,
  input  logic [4:0]          req_shamt_0,
  input  logic [4:0]          req_shamt_1,
  output logic                rsp_valid_0,
  output logic                rsp_valid_1,
  input  logic                rsp_ready_0,
  input  logic                rsp_ready_1,
  output logic [bit_size-1:0] rsp_result_0,
  output logic [bit_size-1:0] rsp_result_1,
  output logic                rsp_zero_0,
  output logic                rsp_zero_1,
  output logic [3:0]          alu_op,
  output logic [bit_size-1:0] alu_src1,
  output logic [bit_size-1:0] alu_src2,
  output logic [4:0]          alu_shamt,
  input  logic [bit_size-1:0] alu_result,
  input  logic                alu_zero
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; requesters hold their fields until then, response consumers see stable
  // rsp_* while valid && !ready. req_ready is the combinational grant.
  rsp_state_e state_0, state_1;
  logic       elig_0, elig_1;
  logic       grant_0, grant_1;

  assign rsp_valid_0 = (state_0 == RSP_FULL);
  assign rsp_valid_1 = (state_1 == RSP_FULL);

  // A full register being drained this cycle can take a new result (pass-through).
  assign elig_0 = rst_n && req_valid_0 && (!rsp_valid_0 || rsp_ready_0);
  assign elig_1 = rst_n && req_valid_1 && (!rsp_valid_1 || rsp_ready_1);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant_0 = elig_0;
  assign grant_1 = elig_1 && !elig_0;
`else
  logic last_grant;

  assign grant_0 = elig_0 && (!elig_1 || last_grant);
  assign grant_1 = elig_1 && (!elig_0 || !last_grant);

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (grant_0) begin
      last_grant <= 1'b0;
    end else if (grant_1) begin
      last_grant <= 1'b1;
    end
  end
`endif

  assign req_ready_0 = grant_0;
  assign req_ready_1 = grant_1;

  always_comb begin
    alu_op    = ALU_NOP;
    alu_src1  = '0;
    alu_src2  = '0;
    alu_shamt = '0;
    if (grant_0) begin
      alu_op    = req_aluop_0;
      alu_src1  = req_src1_0;
      alu_src2  = req_src2_0;
      alu_shamt = req_shamt_0;
    end else if (grant_1) begin
      alu_op    = req_aluop_1;
      alu_src1  = req_src1_1;
      alu_src2  = req_src2_1;
      alu_shamt = req_shamt_1;
    end
  end

  alu_rsp_buf #(.bit_size(bit_size)) u_rsp_buf_0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (grant_0),
    .rsp_ready   (rsp_ready_0),
    .load_result (alu_result),
    .load_zero   (alu_zero),
    .state       (state_0),
    .rsp_result  (rsp_result_0),
    .rsp_zero    (rsp_zero_0)
  );

  alu_rsp_buf #(.bit_size(bit_size)) u_rsp_buf_1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (grant_1),
    .rsp_ready   (rsp_ready_1),
    .load_result (alu_result),
    .load_zero   (alu_zero),
    .state       (state_1),
    .rsp_result  (rsp_result_1),
    .rsp_zero    (rsp_zero_1)
  );

endmodule
